// File: rtl/decode_instr_queue.sv
// Multi-lane in-order instruction queue between predecode and the decoder bank.
// Sparse enqueue masks are compacted; the oldest LANES entries are presented from lane 0.
module decode_instr_queue #(
   parameter int unsigned LANES           = 4,
   parameter int unsigned DEPTH           = 16,
   parameter int unsigned PRED_INFO_WIDTH = 8
) (
   input  logic                                      CLK,
   input  logic                                      nRST,
   input  logic                                      flush,
   input  logic [LANES-1:0]                          enq_valid_by_lane,
   input  logic [LANES-1:0]                          enq_uncompressed_by_lane,
   input  logic [LANES-1:0][31:0]                    enq_instr32_by_lane,
   input  logic [LANES-1:0][PRED_INFO_WIDTH-1:0]     enq_pred_info_chunk0_by_lane,
   input  logic [LANES-1:0][PRED_INFO_WIDTH-1:0]     enq_pred_info_chunk1_by_lane,
   output logic                                      enq_ready,
   output logic [LANES-1:0]                          deq_valid_by_lane,
   output logic [LANES-1:0]                          deq_uncompressed_by_lane,
   output logic [LANES-1:0][31:0]                    deq_instr32_by_lane,
   output logic [LANES-1:0][PRED_INFO_WIDTH-1:0]     deq_pred_info_chunk0_by_lane,
   output logic [LANES-1:0][PRED_INFO_WIDTH-1:0]     deq_pred_info_chunk1_by_lane,
   input  logic [$clog2(LANES+1)-1:0]                deq_ack_count,
   output logic [$clog2(DEPTH+1)-1:0]                occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned PW    = PRED_INFO_WIDTH;

   typedef struct packed {
      logic          uncompressed;
      logic [31:0]   instr32;
      logic [PW-1:0] pred0;
      logic [PW-1:0] pred1;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic [CNT_W-1:0]  lane_offset [LANES];
   logic [CNT_W-1:0]  enq_n;
   logic [CNT_W-1:0]  ack_ext;
   logic [CNT_W-1:0]  eff_ack;
   logic [CNT_W-1:0]  count_next;
   logic              enq_fire;

   // Compaction offsets: each valid lane lands after all lower-numbered valid lanes
   always_comb begin
      enq_n = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_offset[i] = enq_n;
         enq_n          = enq_n + CNT_W'(enq_valid_by_lane[i]);
      end
   end

   // Whole group is dropped when not ready; over-ack is clamped to occupancy
   always_comb begin
      enq_fire   = enq_ready & (|enq_valid_by_lane) & ~flush;
      ack_ext    = CNT_W'(deq_ack_count);
      eff_ack    = (ack_ext < count) ? ack_ext : count;
      count_next = count + (enq_fire ? enq_n : CNT_W'(0)) - eff_ack;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         enq_ready <= 1'b1;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         enq_ready <= 1'b1;
      end else begin
         rd_ptr    <= rd_ptr + PTR_W'(eff_ack);
         if (enq_fire) begin
            wr_ptr <= wr_ptr + PTR_W'(enq_n);
         end
         count     <= count_next;
         enq_ready <= (count_next <= CNT_W'(DEPTH - LANES));
      end
   end

   // Entry storage is intentionally not reset; stale data is masked on the read side
   always_ff @(posedge CLK) begin
      if (nRST && enq_fire) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (enq_valid_by_lane[i]) begin
               mem[wr_ptr + PTR_W'(lane_offset[i])] <= '{
                  uncompressed: enq_uncompressed_by_lane[i],
                  instr32:      enq_instr32_by_lane[i],
                  pred0:        enq_pred_info_chunk0_by_lane[i],
                  pred1:        enq_pred_info_chunk1_by_lane[i]
               };
            end
         end
      end
   end

   assign occupancy = count;

   // Head window: lane i shows entry rd_ptr+i, zeroed when beyond occupancy
   always_comb begin
      entry_t           lane_entry;
      logic [PTR_W-1:0] rd_idx;
      deq_valid_by_lane            = '0;
      deq_uncompressed_by_lane     = '0;
      deq_instr32_by_lane          = '0;
      deq_pred_info_chunk0_by_lane = '0;
      deq_pred_info_chunk1_by_lane = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         rd_idx     = rd_ptr + PTR_W'(i);
         lane_entry = mem[rd_idx];
         if (count > CNT_W'(i)) begin
            deq_valid_by_lane[i]            = 1'b1;
            deq_uncompressed_by_lane[i]     = lane_entry.uncompressed;
            deq_instr32_by_lane[i]          = lane_entry.instr32;
            deq_pred_info_chunk0_by_lane[i] = lane_entry.pred0;
            deq_pred_info_chunk1_by_lane[i] = lane_entry.pred1;
         end
      end
   end

endmodule

// File: tb/tb_decode_instr_queue.sv
// Bench for decode_instr_queue: directed vector table plus random traffic against a queue model.
module tb_decode_instr_queue;

   localparam int unsigned LANES = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PW    = 8;
   localparam int unsigned DW    = 1 + 32 + 2*PW;
   localparam int unsigned NVEC  = 25;

   logic                         CLK = 1'b0;
   logic                         nRST;
   logic                         flush;
   logic [LANES-1:0]             enq_valid_by_lane;
   logic [LANES-1:0]             enq_uncompressed_by_lane;
   logic [LANES-1:0][31:0]       enq_instr32_by_lane;
   logic [LANES-1:0][PW-1:0]     enq_pred_info_chunk0_by_lane;
   logic [LANES-1:0][PW-1:0]     enq_pred_info_chunk1_by_lane;
   logic                         enq_ready;
   logic [LANES-1:0]             deq_valid_by_lane;
   logic [LANES-1:0]             deq_uncompressed_by_lane;
   logic [LANES-1:0][31:0]       deq_instr32_by_lane;
   logic [LANES-1:0][PW-1:0]     deq_pred_info_chunk0_by_lane;
   logic [LANES-1:0][PW-1:0]     deq_pred_info_chunk1_by_lane;
   logic [2:0]                   deq_ack_count;
   logic [4:0]                   occupancy;

   int checks   = 0;
   int failures = 0;

   typedef logic [DW-1:0] ent_t;
   ent_t mq[$];

   typedef struct {
      logic [3:0]       mask;
      logic [3:0][31:0] instr;
      logic [2:0]       ack;
      logic             flsh;
      logic [4:0]       occ;
      logic             rdy;
      logic [3:0]       vld;
      logic [31:0]      l0;
      logic [31:0]      l1;
   } vec_t;

   vec_t tbl [NVEC];

   decode_instr_queue #(.LANES(LANES), .DEPTH(DEPTH), .PRED_INFO_WIDTH(PW)) dut (
      .CLK                          (CLK),
      .nRST                         (nRST),
      .flush                        (flush),
      .enq_valid_by_lane            (enq_valid_by_lane),
      .enq_uncompressed_by_lane     (enq_uncompressed_by_lane),
      .enq_instr32_by_lane          (enq_instr32_by_lane),
      .enq_pred_info_chunk0_by_lane (enq_pred_info_chunk0_by_lane),
      .enq_pred_info_chunk1_by_lane (enq_pred_info_chunk1_by_lane),
      .enq_ready                    (enq_ready),
      .deq_valid_by_lane            (deq_valid_by_lane),
      .deq_uncompressed_by_lane     (deq_uncompressed_by_lane),
      .deq_instr32_by_lane          (deq_instr32_by_lane),
      .deq_pred_info_chunk0_by_lane (deq_pred_info_chunk0_by_lane),
      .deq_pred_info_chunk1_by_lane (deq_pred_info_chunk1_by_lane),
      .deq_ack_count                (deq_ack_count),
      .occupancy                    (occupancy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t pack_ent(input logic u, input logic [31:0] ins,
                                     input logic [PW-1:0] a, input logic [PW-1:0] b);
      return {u, ins, a, b};
   endfunction

   // Reference: queue of entries; pops the acked head, then appends valid lanes in order
   task automatic model_step();
      int n;
      int eff;
      bit rdy;
      n   = mq.size();
      eff = (int'(deq_ack_count) < n) ? int'(deq_ack_count) : n;
      rdy = (DEPTH - n) >= LANES;
      if (!nRST || flush) begin
         mq.delete();
      end else begin
         for (int k = 0; k < eff; k++) void'(mq.pop_front());
         if (rdy && (|enq_valid_by_lane)) begin
            for (int i = 0; i < LANES; i++) begin
               if (enq_valid_by_lane[i])
                  mq.push_back(pack_ent(enq_uncompressed_by_lane[i], enq_instr32_by_lane[i],
                                        enq_pred_info_chunk0_by_lane[i],
                                        enq_pred_info_chunk1_by_lane[i]));
            end
         end
      end
   endtask

   task automatic check_model();
      int   n;
      ent_t e;
      logic [3:0] inv;
      n = mq.size();
      chk("model_occupancy", 64'(occupancy), 64'(n));
      chk("model_enq_ready", 64'(enq_ready), 64'((DEPTH - n) >= LANES));
      for (int i = 0; i < LANES; i++) begin
         e = (i < n) ? mq[i] : '0;
         chk($sformatf("model_valid%0d", i), 64'(deq_valid_by_lane[i]), 64'(i < n));
         chk($sformatf("model_data%0d", i),
             64'(pack_ent(deq_uncompressed_by_lane[i], deq_instr32_by_lane[i],
                          deq_pred_info_chunk0_by_lane[i], deq_pred_info_chunk1_by_lane[i])),
             64'(e));
      end
      inv = dut.rd_ptr + dut.count[3:0];
      chk("ptr_invariant", 64'(dut.wr_ptr), 64'(inv));
      chk("count_bound", 64'(dut.count <= 5'(DEPTH)), 64'(1));
   endtask

   task automatic cycle();
      @(posedge CLK);
      model_step();
      #1;
      check_model();
   endtask

   task automatic drive_instr(input logic [3:0] mask, input logic [3:0][31:0] instr);
      enq_valid_by_lane   = mask;
      enq_instr32_by_lane = instr;
      for (int i = 0; i < LANES; i++) begin
         enq_uncompressed_by_lane[i]     = instr[i][0];
         enq_pred_info_chunk0_by_lane[i] = instr[i][7:0];
         enq_pred_info_chunk1_by_lane[i] = instr[i][15:8];
      end
   endtask

   function automatic vec_t mk(input logic [3:0] mask, input logic [31:0] base, input logic [2:0] ack,
                               input logic flsh, input logic [4:0] occ, input logic rdy,
                               input logic [3:0] vld, input logic [31:0] l0, input logic [31:0] l1);
      vec_t v;
      v.mask = mask;
      for (int i = 0; i < 4; i++) v.instr[i] = base + 32'(i);
      v.ack = ack; v.flsh = flsh; v.occ = occ; v.rdy = rdy; v.vld = vld; v.l0 = l0; v.l1 = l1;
      return v;
   endfunction

   initial begin
      nRST = 1'b0;
      flush = 1'b0;
      deq_ack_count = '0;
      drive_instr(4'b0000, '0);

      // Sparse compaction, then flush to a clean base
      tbl[0] = mk(4'b1010, 32'h0, 3'd0, 1'b0, 5'd2, 1'b1, 4'b0011, 32'h00A00093, 32'h00B00113);
      tbl[0].instr[1] = 32'h00A00093;
      tbl[0].instr[3] = 32'h00B00113;
      tbl[1]  = mk(4'b0000, 32'h0,   3'd0, 1'b1, 5'd0,  1'b1, 4'b0000, 32'h0,   32'h0);
      // Fill to DEPTH, ack 3 twice, then simultaneous enq/ack at count 10
      tbl[2]  = mk(4'b1111, 32'h100, 3'd0, 1'b0, 5'd4,  1'b1, 4'b1111, 32'h100, 32'h101);
      tbl[3]  = mk(4'b1111, 32'h200, 3'd0, 1'b0, 5'd8,  1'b1, 4'b1111, 32'h100, 32'h101);
      tbl[4]  = mk(4'b1111, 32'h300, 3'd0, 1'b0, 5'd12, 1'b1, 4'b1111, 32'h100, 32'h101);
      tbl[5]  = mk(4'b1111, 32'h400, 3'd0, 1'b0, 5'd16, 1'b0, 4'b1111, 32'h100, 32'h101);
      tbl[6]  = mk(4'b0000, 32'h0,   3'd3, 1'b0, 5'd13, 1'b0, 4'b1111, 32'h103, 32'h200);
      tbl[7]  = mk(4'b0000, 32'h0,   3'd3, 1'b0, 5'd10, 1'b1, 4'b1111, 32'h202, 32'h203);
      tbl[8]  = mk(4'b1111, 32'h500, 3'd2, 1'b0, 5'd12, 1'b1, 4'b1111, 32'h300, 32'h301);
      tbl[9]  = mk(4'b1111, 32'h600, 3'd0, 1'b0, 5'd16, 1'b0, 4'b1111, 32'h300, 32'h301);
      // Drain across the 15->0 boundary, then over-ack at count 1
      tbl[10] = mk(4'b0000, 32'h0,   3'd4, 1'b0, 5'd12, 1'b1, 4'b1111, 32'h400, 32'h401);
      tbl[11] = mk(4'b0000, 32'h0,   3'd4, 1'b0, 5'd8,  1'b1, 4'b1111, 32'h500, 32'h501);
      tbl[12] = mk(4'b0000, 32'h0,   3'd4, 1'b0, 5'd4,  1'b1, 4'b1111, 32'h600, 32'h601);
      tbl[13] = mk(4'b0000, 32'h0,   3'd3, 1'b0, 5'd1,  1'b1, 4'b0001, 32'h603, 32'h0);
      tbl[14] = mk(4'b0000, 32'h0,   3'd4, 1'b0, 5'd0,  1'b1, 4'b0000, 32'h0,   32'h0);
      // Build count 9, flush against enq 4 + ack 2, then a fresh enqueue at lane 0
      tbl[15] = mk(4'b1111, 32'h700, 3'd0, 1'b0, 5'd4,  1'b1, 4'b1111, 32'h700, 32'h701);
      tbl[16] = mk(4'b1111, 32'h800, 3'd0, 1'b0, 5'd8,  1'b1, 4'b1111, 32'h700, 32'h701);
      tbl[17] = mk(4'b0001, 32'h900, 3'd0, 1'b0, 5'd9,  1'b1, 4'b1111, 32'h700, 32'h701);
      tbl[18] = mk(4'b1111, 32'hA00, 3'd2, 1'b1, 5'd0,  1'b1, 4'b0000, 32'h0,   32'h0);
      tbl[19] = mk(4'b0100, 32'hB00, 3'd0, 1'b0, 5'd1,  1'b1, 4'b0001, 32'hB02, 32'h0);
      // Walk wr_ptr to 13 so a full group straddles index 15->0
      tbl[20] = mk(4'b1111, 32'hC00, 3'd1, 1'b0, 5'd4,  1'b1, 4'b1111, 32'hC00, 32'hC01);
      tbl[21] = mk(4'b1111, 32'hD00, 3'd4, 1'b0, 5'd4,  1'b1, 4'b1111, 32'hD00, 32'hD01);
      tbl[22] = mk(4'b1111, 32'hE00, 3'd4, 1'b0, 5'd4,  1'b1, 4'b1111, 32'hE00, 32'hE01);
      tbl[23] = mk(4'b1111, 32'hF00, 3'd4, 1'b0, 5'd4,  1'b1, 4'b1111, 32'hF00, 32'hF01);
      tbl[24] = mk(4'b0000, 32'h0,   3'd2, 1'b0, 5'd2,  1'b1, 4'b0011, 32'hF02, 32'hF03);

      cycle();
      cycle();
      chk("reset_occupancy", 64'(occupancy), 64'(0));
      chk("reset_enq_ready", 64'(enq_ready), 64'(1));
      chk("reset_deq_valid", 64'(deq_valid_by_lane), 64'(0));
      chk("reset_lane0_instr", 64'(deq_instr32_by_lane[0]), 64'(0));
      nRST = 1'b1;

      for (int v = 0; v < NVEC; v++) begin
         drive_instr(tbl[v].mask, tbl[v].instr);
         deq_ack_count = tbl[v].ack;
         flush         = tbl[v].flsh;
         cycle();
         chk($sformatf("vec%0d_occupancy", v), 64'(occupancy), 64'(tbl[v].occ));
         chk($sformatf("vec%0d_enq_ready", v), 64'(enq_ready), 64'(tbl[v].rdy));
         chk($sformatf("vec%0d_deq_valid", v), 64'(deq_valid_by_lane), 64'(tbl[v].vld));
         chk($sformatf("vec%0d_lane0", v), 64'(deq_instr32_by_lane[0]), 64'(tbl[v].l0));
         chk($sformatf("vec%0d_lane1", v), 64'(deq_instr32_by_lane[1]), 64'(tbl[v].l1));
      end

      // Random traffic: mostly honours enq_ready, with occasional violations, flushes and resets
      for (int c = 0; c < 600; c++) begin
         enq_valid_by_lane = 4'($urandom);
         if (!enq_ready && ($urandom_range(0, 7) != 0)) enq_valid_by_lane = '0;
         enq_uncompressed_by_lane = 4'($urandom);
         for (int i = 0; i < LANES; i++) begin
            enq_instr32_by_lane[i]          = $urandom;
            enq_pred_info_chunk0_by_lane[i] = PW'($urandom);
            enq_pred_info_chunk1_by_lane[i] = PW'($urandom);
         end
         deq_ack_count = 3'($urandom_range(0, 4));
         flush         = ($urandom_range(0, 39) == 0);
         nRST          = ($urandom_range(0, 79) != 0);
         cycle();
      end

      nRST = 1'b1;
      flush = 1'b0;
      enq_valid_by_lane = '0;
      deq_ack_count = '0;
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
